// File: rtl/vram_arb_pkg.sv
// Shared widths, the CPU write entry type and the clear-engine state encoding.
package vram_arb_pkg;

   localparam int VRAM_ADDR_W = 10;
   localparam int VRAM_DATA_W = 8;

   typedef struct packed {
      logic [VRAM_ADDR_W-1:0] addr;
      logic [VRAM_DATA_W-1:0] data;
   } wr_entry_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } clr_state_t;

   // Any length with the top bit set is at least the full VRAM size.
   function automatic logic [VRAM_ADDR_W:0] clamp_len(input logic [VRAM_ADDR_W:0] len);
      if (len[VRAM_ADDR_W])
         return {1'b1, {VRAM_ADDR_W{1'b0}}};
      return len;
   endfunction

endpackage

// File: rtl/vram_write_arbiter_if.sv
// CPU write, clear request and VRAM port A signals of the write arbiter.
interface vram_write_arbiter_if
   import vram_arb_pkg::*;
#(
   parameter int ADDR_W = VRAM_ADDR_W,
   parameter int DATA_W = VRAM_DATA_W
);

   logic              vsync;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_data;
   logic              cpu_full;
   logic              overflow;
   logic              clr_start;
   logic [ADDR_W-1:0] clr_base;
   logic [ADDR_W:0]   clr_len;
   logic [DATA_W-1:0] clr_value;
   logic              clr_busy;
   logic              clr_done;
   logic [ADDR_W-1:0] v_ada;
   logic [DATA_W-1:0] v_din;
   logic              v_cea;

   modport master (
      output vsync, cpu_we, cpu_addr, cpu_data,
      output clr_start, clr_base, clr_len, clr_value,
      input  cpu_full, overflow, clr_busy, clr_done,
      input  v_ada, v_din, v_cea
   );

   modport slave (
      input  vsync, cpu_we, cpu_addr, cpu_data,
      input  clr_start, clr_base, clr_len, clr_value,
      output cpu_full, overflow, clr_busy, clr_done,
      output v_ada, v_din, v_cea
   );

endinterface

// File: rtl/vram_wr_fifo.sv
// Small synchronous FIFO with a registered occupancy count.
// Push is refused when full (even with a same-edge pop); pop data is the head entry, valid when not empty.
module vram_wr_fifo
   import vram_arb_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = wr_entry_t
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  T                       push_dat,
   input  logic                   pop,
   output T                       pop_dat,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   T                 mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign pop_dat = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/vram_write_arbiter.sv
// Shares the VRAM write port between buffered CPU byte writes (strict priority) and a fill engine.
// One write per cycle; CPU write appears one cycle after it is pushed; FIFO overflow drops and is sticky.
module vram_write_arbiter
   import vram_arb_pkg::*;
#(
   parameter int ADDR_W      = VRAM_ADDR_W,
   parameter int DATA_W      = VRAM_DATA_W,
   parameter int FIFO_DEPTH  = 4,
   parameter bit VBLANK_ONLY = 1'b0
) (
   input logic                 clk,
   input logic                 rst,
   vram_write_arbiter_if.slave bus
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int LEN_W = ADDR_W + 1;

   // vsync synchroniser and write gate
   logic vs_meta;
   logic vs_s;
   logic gate;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_meta <= 1'b0;
         vs_s    <= 1'b0;
      end else begin
         vs_meta <= bus.vsync;
         vs_s    <= vs_meta;
      end
   end

   assign gate = !VBLANK_ONLY || vs_s;

   wr_entry_t        push_dat;
   wr_entry_t        head;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic             overflow_q;

   assign push_dat = '{addr: bus.cpu_addr, data: bus.cpu_data};

   vram_wr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (wr_entry_t)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (bus.cpu_we),
      .push_dat (push_dat),
      .pop      (fifo_pop),
      .pop_dat  (head),
      .count    (fifo_count),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign bus.cpu_full = (fifo_count == CNT_W'(FIFO_DEPTH));
   assign bus.overflow = overflow_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         overflow_q <= 1'b0;
      else if (bus.cpu_we && fifo_full)
         overflow_q <= 1'b1;
   end

   // Clear engine
   clr_state_t        state;
   clr_state_t        state_nxt;
   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W-1:0] cur_addr_nxt;
   logic [LEN_W-1:0]  remaining;
   logic [LEN_W-1:0]  remaining_nxt;
   logic [DATA_W-1:0] value;
   logic [DATA_W-1:0] value_nxt;
   logic              clr_issue;

   assign fifo_pop  = gate && !fifo_empty;
   assign clr_issue = gate && fifo_empty && (state == RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cur_addr  <= '0;
         remaining <= '0;
         value     <= '0;
      end else begin
         state     <= state_nxt;
         cur_addr  <= cur_addr_nxt;
         remaining <= remaining_nxt;
         value     <= value_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cur_addr_nxt  = cur_addr;
      remaining_nxt = remaining;
      value_nxt     = value;
      bus.clr_busy  = 1'b0;
      bus.clr_done  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.clr_start) begin
               if (bus.clr_len == '0) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt     = RUN;
                  cur_addr_nxt  = bus.clr_base;
                  remaining_nxt = clamp_len(bus.clr_len);
                  value_nxt     = bus.clr_value;
               end
            end
         end
         RUN: begin
            bus.clr_busy = 1'b1;
            if (clr_issue) begin
               cur_addr_nxt  = cur_addr + 1'b1;
               remaining_nxt = remaining - 1'b1;
               if (remaining == LEN_W'(1))
                  state_nxt = DONE;
            end
         end
         DONE: begin
            bus.clr_done = 1'b1;
            state_nxt    = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Registered VRAM port; address/data hold when no write is issued.
   logic              v_cea_q;
   logic [ADDR_W-1:0] v_ada_q;
   logic [DATA_W-1:0] v_din_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_cea_q <= 1'b0;
         v_ada_q <= '0;
         v_din_q <= '0;
      end else if (fifo_pop) begin
         v_cea_q <= 1'b1;
         v_ada_q <= head.addr;
         v_din_q <= head.data;
      end else if (clr_issue) begin
         v_cea_q <= 1'b1;
         v_ada_q <= cur_addr;
         v_din_q <= value;
      end else begin
         v_cea_q <= 1'b0;
      end
   end

   assign bus.v_cea = v_cea_q;
   assign bus.v_ada = v_ada_q;
   assign bus.v_din = v_din_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Two arbiters (ungated and vblank-gated) driven in parallel and scored against a queue-based model.
`timescale 1ns/1ps
module tb_vram_write_arbiter;
   import vram_arb_pkg::*;

   localparam int AW    = VRAM_ADDR_W;
   localparam int DW    = VRAM_DATA_W;
   localparam int DEPTH = 4;
   localparam int VSIZE = 1 << AW;

   typedef struct { int cyc; int addr; int data; } exp_t;
   typedef struct { int addr; int data; } ent_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          vsync;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_data;
   logic          clr_start;
   logic [AW-1:0] clr_base;
   logic [AW:0]   clr_len;
   logic [DW-1:0] clr_value;

   always #5 clk = ~clk;

   vram_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
   vram_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

   assign bus0.vsync = vsync;     assign bus1.vsync = vsync;
   assign bus0.cpu_we = cpu_we;   assign bus1.cpu_we = cpu_we;
   assign bus0.cpu_addr = cpu_addr; assign bus1.cpu_addr = cpu_addr;
   assign bus0.cpu_data = cpu_data; assign bus1.cpu_data = cpu_data;
   assign bus0.clr_start = clr_start; assign bus1.clr_start = clr_start;
   assign bus0.clr_base = clr_base; assign bus1.clr_base = clr_base;
   assign bus0.clr_len = clr_len;   assign bus1.clr_len = clr_len;
   assign bus0.clr_value = clr_value; assign bus1.clr_value = clr_value;

   vram_write_arbiter #(.FIFO_DEPTH(DEPTH), .VBLANK_ONLY(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
   vram_write_arbiter #(.FIFO_DEPTH(DEPTH), .VBLANK_ONLY(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

   // Reference model: index 0 never gated, index 1 gated by vsync seen two edges late.
   ent_t cpu_q [2][$];
   exp_t wr_q  [2][$];
   bit   m_active [2];
   bit   m_done   [2];
   bit   m_ovf    [2];
   int   m_addr   [2];
   int   m_rem    [2];
   int   m_val    [2];
   bit   vs1, vs2;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         cpu_q[i].delete();
         wr_q[i].delete();
         m_active[i] = 1'b0;
         m_done[i]   = 1'b0;
         m_ovf[i]    = 1'b0;
         m_addr[i]   = 0;
         m_rem[i]    = 0;
         m_val[i]    = 0;
      end
      vs1 = 1'b0;
      vs2 = 1'b0;
   endfunction

   function automatic void model_step();
      bit   gate, was_done, was_active;
      int   pre_cnt;
      ent_t e;
      cyc++;
      if (rst) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 2; i++) begin
         gate       = (i == 0) || vs2;
         pre_cnt    = cpu_q[i].size();
         was_done   = m_done[i];
         was_active = m_active[i];
         m_done[i]  = 1'b0;
         if (gate && pre_cnt > 0) begin
            e = cpu_q[i].pop_front();
            wr_q[i].push_back('{cyc, e.addr, e.data});
         end else if (gate && was_active) begin
            wr_q[i].push_back('{cyc, m_addr[i], m_val[i]});
            m_addr[i] = (m_addr[i] + 1) % VSIZE;
            m_rem[i]--;
            if (m_rem[i] == 0) begin
               m_active[i] = 1'b0;
               m_done[i]   = 1'b1;
            end
         end
         if (clr_start && !was_active && !was_done) begin
            if (clr_len == 0) begin
               m_done[i] = 1'b1;
            end else begin
               m_active[i] = 1'b1;
               m_addr[i]   = int'(clr_base);
               m_rem[i]    = (int'(clr_len) > VSIZE) ? VSIZE : int'(clr_len);
               m_val[i]    = int'(clr_value);
            end
         end
         if (cpu_we) begin
            if (pre_cnt == DEPTH) m_ovf[i] = 1'b1;
            else cpu_q[i].push_back('{int'(cpu_addr), int'(cpu_data)});
         end
      end
      vs2 = vs1;
      vs1 = vsync;
   endfunction

   function automatic void check(string name, int act, int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, req);
      end
   endfunction

   function automatic void monitor();
      int   cea[2], ada[2], din[2], full[2], ovf[2], busy[2], done[2];
      bit   want;
      exp_t e;
      cea[0] = int'(bus0.v_cea);  cea[1] = int'(bus1.v_cea);
      ada[0] = int'(bus0.v_ada);  ada[1] = int'(bus1.v_ada);
      din[0] = int'(bus0.v_din);  din[1] = int'(bus1.v_din);
      full[0] = int'(bus0.cpu_full); full[1] = int'(bus1.cpu_full);
      ovf[0] = int'(bus0.overflow); ovf[1] = int'(bus1.overflow);
      busy[0] = int'(bus0.clr_busy); busy[1] = int'(bus1.clr_busy);
      done[0] = int'(bus0.clr_done); done[1] = int'(bus1.clr_done);
      for (int i = 0; i < 2; i++) begin
         want = (wr_q[i].size() > 0) && (wr_q[i][0].cyc == cyc);
         check($sformatf("v_cea[%0d]", i), cea[i], int'(want));
         if (want) begin
            e = wr_q[i].pop_front();
            if (cea[i] != 0) begin
               check($sformatf("v_ada[%0d]", i), ada[i], e.addr);
               check($sformatf("v_din[%0d]", i), din[i], e.data);
            end
         end
         if (rst) begin
            check($sformatf("rst_v_ada[%0d]", i), ada[i], 0);
            check($sformatf("rst_v_din[%0d]", i), din[i], 0);
         end
         check($sformatf("cpu_full[%0d]", i), full[i], int'(cpu_q[i].size() == DEPTH));
         check($sformatf("overflow[%0d]", i), ovf[i], int'(m_ovf[i]));
         check($sformatf("clr_busy[%0d]", i), busy[i], int'(m_active[i]));
         check($sformatf("clr_done[%0d]", i), done[i], int'(m_done[i]));
      end
   endfunction

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      monitor();
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(int a, int d);
      cpu_we   = 1'b1;
      cpu_addr = AW'(a);
      cpu_data = DW'(d);
      tick();
      cpu_we = 1'b0;
   endtask

   task automatic clear(int base, int len, int val);
      clr_start = 1'b1;
      clr_base  = AW'(base);
      clr_len   = (AW+1)'(len);
      clr_value = DW'(val);
      tick();
      clr_start = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      model_reset();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_idle(int limit);
      bit idle;
      idle = 1'b0;
      for (int n = 0; n < limit && !idle; n++) begin
         tick();
         idle = 1'b1;
         for (int i = 0; i < 2; i++)
            if (cpu_q[i].size() != 0 || wr_q[i].size() != 0 || m_active[i] || m_done[i])
               idle = 1'b0;
      end
      check("drain_within_budget", int'(idle), 1);
   endtask

   initial begin
      rst = 1'b1; vsync = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_data = '0;
      clr_start = 1'b0; clr_base = '0; clr_len = '0; clr_value = '0;
      model_reset();
      repeat (3) tick();
      rst = 1'b0;
      repeat (3) tick();

      // single write, then wrapped clear, then CPU priority over a running clear
      cpu_write(12'h005, 8'h41);
      wait_idle(20);
      clear(12'h3FE, 4, 8'h20);
      wait_idle(20);
      clear(12'h000, 16, 8'h55);
      tick();
      cpu_write(12'h100, 8'hA0);
      cpu_write(12'h101, 8'hA1);
      cpu_write(12'h102, 8'hA2);
      wait_idle(40);

      // gated FIFO fill and overflow, then release
      vsync = 1'b0;
      repeat (3) tick();
      for (int k = 0; k < 5; k++) cpu_write(12'h200 + k, 8'h10 + k);
      repeat (3) tick();
      vsync = 1'b1;
      wait_idle(20);

      // zero-length clear and start while busy
      clear(12'h050, 0, 8'h77);
      wait_idle(10);
      clear(12'h200, 8, 8'h66);
      tick();
      clear(12'h300, 8, 8'h99);
      wait_idle(30);

      // reset mid-clear, then a fresh clear
      clear(12'h080, 64, 8'hAA);
      repeat (10) tick();
      pulse_reset();
      repeat (3) tick();
      clear(12'h010, 5, 8'h33);
      wait_idle(30);

      // randomized mix
      for (int n = 0; n < 3000; n++) begin
         cpu_we    = ($urandom_range(0, 2) == 0);
         cpu_addr  = AW'($urandom_range(0, VSIZE - 1));
         cpu_data  = DW'($urandom_range(0, 255));
         clr_start = ($urandom_range(0, 39) == 0);
         clr_base  = AW'($urandom_range(0, VSIZE - 1));
         clr_len   = ($urandom_range(0, 9) == 0) ? (AW+1)'($urandom_range(1000, 2047))
                                                 : (AW+1)'($urandom_range(0, 24));
         clr_value = DW'($urandom_range(0, 255));
         if ($urandom_range(0, 29) == 0) vsync = ~vsync;
         if ($urandom_range(0, 1499) == 0) begin
            rst = 1'b1;
            model_reset();
         end else begin
            rst = 1'b0;
         end
         tick();
      end
      rst = 1'b0; cpu_we = 1'b0; clr_start = 1'b0; vsync = 1'b1;
      wait_idle(3000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
